id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and EX-side operand selection for the pipelined processor. It captures decoded fields from ID and resolves register forwarding from the MEM and WB stages. It then drives the ALU and barrel-shifter operands: shift amount from `ex_alu_a[4:0]`, shifted value from `ex_alu_b`, and shift op from `ex_alufun[1:0]`. It also detects load-use hazards against the instruction currently in ID and supports stall and flush with a deferred-flush rule.

## Interface
- No parameters; the datapath is fixed at 32 bits and register addresses at 5 bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous reset, active-low (`reset==0` at a rising edge resets).
- `stall` in 1: hold all stage registers.
- `flush` in 1: replace the next captured entry with a bubble.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs_data`, `id_rt_data` in 32 each: register-file read data.
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr` in 5 each.
- `id_shamt` in 5: instruction shift-amount field.
- `id_imm32` in 32: extended immediate.
- `id_alusrc_a` in 1: 0 selects rs; 1 selects `{27'b0, shamt}`.
- `id_alusrc_b` in 1: 0 selects rt; 1 selects imm.
- `id_alufun` in 6.
- `id_regwrite`, `id_memread`, `id_memwrite` in 1 each.
- `mem_regwrite` in 1, `mem_rd_addr` in 5, `mem_result` in 32: EX/MEM forward source.
- `wb_regwrite` in 1, `wb_rd_addr` in 5, `wb_result` in 32: MEM/WB forward source.
- `ex_valid` out 1.
- `ex_alu_a`, `ex_alu_b` out 32 each.
- `ex_alufun` out 6.
- `ex_store_data` out 32: forwarded rt.
- `ex_rd_addr` out 5.
- `ex_regwrite`, `ex_memread`, `ex_memwrite` out 1 each.
- `ex_fwd_a`, `ex_fwd_b` out 2 each: 00 register, 01 WB, 10 MEM.
- `load_use_hazard` out 1: combinational request to ID to stall.

## Operation
- **Registered fields:** valid, rs/rt data, rs/rt/rd addresses, shamt, imm, alusrc_a/b, alufun, regwrite/memread/memwrite, and `pend_flush`.
- **Update priority each cycle:**
  1. Reset: all registers become 0, so the stage holds a bubble.
  2. `stall` is high: all registers hold; `pend_flush <= pend_flush | flush`.
  3. `flush` or `pend_flush` is high: load a bubble and clear `pend_flush`.
  4. Otherwise: capture the ID inputs. Control bits are ANDed with `id_valid`, so an invalid ID loads a bubble.
- **Bubble:** valid, regwrite, memread, memwrite and alufun are all 0. Data fields are don't-care but are reset to 0.
- **Forwarding (combinational, from registered fields and current MEM/WB inputs), per source s in {rs, rt}:**
  - MEM when `mem_regwrite && mem_rd_addr!=0 && mem_rd_addr==s_addr`.
  - Otherwise WB under the same test on the WB inputs.
  - Otherwise the registered data.
  - MEM always has priority over WB.
  - Address 0 never forwards.
- **Operand selection:**
  - `ex_alu_a` = alusrc_a ? `{27'b0, shamt}` : fwd_rs.
  - `ex_alu_b` = alusrc_b ? imm : fwd_rt.
  - `ex_store_data` = fwd_rt.
  - Variable shifts (sllv/srlv/srav) use alusrc_a=0, so the shifter uses `fwd_rs[4:0]`; the upper bits are ignored downstream.
- **`ex_fwd_a`/`ex_fwd_b`:** report the chosen source even when the alusrc mux bypasses it. All are 00 when `ex_valid==0`.
- **Load-use hazard:** `load_use_hazard = ex_valid & ex_memread & ex_rd_addr!=0 & id_valid & (ex_rd_addr==id_rs_addr | ex_rd_addr==id_rt_addr)`. The surrounding control responds by holding IF/ID and asserting `flush` here.

## Timing
- Latency from ID inputs to registered `ex_*` outputs is 1 cycle.
- Forwarding and operand muxing are combinational within the EX cycle.
- Every output is 0 in the cycle after reset. Outputs driven by the muxes are 0 unless MEM/WB forwarding applies to address 0, which is prevented.
- `stall` and `flush` are sampled at the rising edge.
- A flush that arrives during a stall takes effect at the first non-stall edge. Any number of flushes during one stall collapse to a single bubble.
- If `reset` goes low mid-stall, it clears `pend_flush` as well.
- While stalled, outputs stay stable except for forwarded values, which track the MEM/WB inputs.

## Test plan
- **Reset:** drive `reset=0` for 2 cycles with random ID inputs. Require `ex_valid=0`, all controls 0, `ex_alu_a=ex_alu_b=0` and `load_use_hazard=0`.
- **Immediate shift:** ID sll with shamt=5, rt=$2 holding 0x0000_0003, alusrc_a=1, no forwarding. The next cycle must show `ex_alu_a=5`, `ex_alu_b=3` and `ex_fwd_b=00`.
- **Forward priority:** an EX instruction reads rs=$4 while MEM writes $4=0x11 and WB writes $4=0x22. Require `ex_alu_a=0x11` and `ex_fwd_a=10`.
  - With MEM regwrite=0, require 0x22 and `ex_fwd_a=01`.
  - With MEM rd=$0, require no MEM forward.
- **Load-use:** EX holds lw with rd=$8 and ID reads rt=$8. Require `load_use_hazard=1`.
  - Assert `flush` and require a bubble next cycle.
  - With rd=$0, require `load_use_hazard=0`.
- **Stall with deferred flush:** load instruction X, then stall 3 cycles with `flush` pulsed in cycle 2. Require X held for all 3 cycles, then a bubble, then normal capture the following cycle.
- **Variable shift:** srav with rs forwarded from MEM=0xFFFF_FFE3 and rt=0x8000_0000. Require `ex_alu_a=0xFFFF_FFE3`, whose low 5 bits are 3, and `ex_alu_b=0x8000_0000`.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-stage fields, MEM/WB forward sources and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic [4:0]  id_shamt;
    logic [31:0] id_imm32;
    logic        id_alusrc_a;
    logic        id_alusrc_b;
    logic [5:0]  id_alufun;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic        mem_regwrite;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] ex_alu_a;
    logic [31:0] ex_alu_b;
    logic [5:0]  ex_alufun;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [1:0]  ex_fwd_a;
    logic [1:0]  ex_fwd_b;
    logic        load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
               id_shamt, id_imm32, id_alusrc_a, id_alusrc_b, id_alufun, id_regwrite, id_memread,
               id_memwrite, mem_regwrite, mem_rd_addr, mem_result, wb_regwrite, wb_rd_addr, wb_result,
        input  ex_valid, ex_alu_a, ex_alu_b, ex_alufun, ex_store_data, ex_rd_addr, ex_regwrite,
               ex_memread, ex_memwrite, ex_fwd_a, ex_fwd_b, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
               id_shamt, id_imm32, id_alusrc_a, id_alusrc_b, id_alufun, id_regwrite, id_memread,
               id_memwrite, mem_regwrite, mem_rd_addr, mem_result, wb_regwrite, wb_rd_addr, wb_result,
        output ex_valid, ex_alu_a, ex_alu_b, ex_alufun, ex_store_data, ex_rd_addr, ex_regwrite,
               ex_memread, ex_memwrite, ex_fwd_a, ex_fwd_b, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB forwarding, ALU operand muxing,
// load-use detection and stall/flush handling where a flush seen during a stall is deferred.
module id_ex_stage (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        alusrc_a;
        logic        alusrc_b;
        logic [5:0]  alufun;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } ex_fields_t;

    ex_fields_t  r_ex;
    ex_fields_t  w_id;
    logic        r_pend_flush;
    logic        w_mem_a, w_wb_a, w_mem_b, w_wb_b;
    logic [31:0] w_fwd_rs, w_fwd_rt;

    // An invalid ID slot is captured as an all-zero bubble.
    assign w_id = bus.id_valid ? ex_fields_t'{
        valid: 1'b1, rs_data: bus.id_rs_data, rt_data: bus.id_rt_data,
        rs_addr: bus.id_rs_addr, rt_addr: bus.id_rt_addr, rd_addr: bus.id_rd_addr,
        shamt: bus.id_shamt, imm: bus.id_imm32, alusrc_a: bus.id_alusrc_a,
        alusrc_b: bus.id_alusrc_b, alufun: bus.id_alufun, regwrite: bus.id_regwrite,
        memread: bus.id_memread, memwrite: bus.id_memwrite} : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex         <= '0;
            r_pend_flush <= 1'b0;
        end else if (bus.stall) begin
            r_pend_flush <= r_pend_flush | bus.flush;
        end else begin
            r_ex         <= (bus.flush || r_pend_flush) ? '0 : w_id;
            r_pend_flush <= 1'b0;
        end
    end

    assign w_mem_a = bus.mem_regwrite && bus.mem_rd_addr != 5'd0 && bus.mem_rd_addr == r_ex.rs_addr;
    assign w_wb_a  = bus.wb_regwrite  && bus.wb_rd_addr  != 5'd0 && bus.wb_rd_addr  == r_ex.rs_addr;
    assign w_mem_b = bus.mem_regwrite && bus.mem_rd_addr != 5'd0 && bus.mem_rd_addr == r_ex.rt_addr;
    assign w_wb_b  = bus.wb_regwrite  && bus.wb_rd_addr  != 5'd0 && bus.wb_rd_addr  == r_ex.rt_addr;

    assign w_fwd_rs = w_mem_a ? bus.mem_result : w_wb_a ? bus.wb_result : r_ex.rs_data;
    assign w_fwd_rt = w_mem_b ? bus.mem_result : w_wb_b ? bus.wb_result : r_ex.rt_data;

    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_alu_a      = r_ex.alusrc_a ? {27'b0, r_ex.shamt} : w_fwd_rs;
    assign bus.ex_alu_b      = r_ex.alusrc_b ? r_ex.imm : w_fwd_rt;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ex_alufun     = r_ex.alufun;
    assign bus.ex_rd_addr    = r_ex.rd_addr;
    assign bus.ex_regwrite   = r_ex.regwrite;
    assign bus.ex_memread    = r_ex.memread;
    assign bus.ex_memwrite   = r_ex.memwrite;
    assign bus.ex_fwd_a      = !r_ex.valid ? 2'b00 : w_mem_a ? 2'b10 : w_wb_a ? 2'b01 : 2'b00;
    assign bus.ex_fwd_b      = !r_ex.valid ? 2'b00 : w_mem_b ? 2'b10 : w_wb_b ? 2'b01 : 2'b00;

    assign bus.load_use_hazard = r_ex.valid && r_ex.memread && r_ex.rd_addr != 5'd0 && bus.id_valid &&
                                 (r_ex.rd_addr == bus.id_rs_addr || r_ex.rd_addr == bus.id_rt_addr);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors for capture/forwarding/hazard, plus hand-written
// sequences for reset, load-use flush, stall with deferred flush and reset during a stall.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if bus();

    id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] rs_d, rt_d;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] imm;
        logic        asa, asb;
        logic [5:0]  fun;
        logic        rw, mr, mw;
        logic        m_rw;
        logic [4:0]  m_rd;
        logic [31:0] m_res;
        logic        w_rw;
        logic [4:0]  w_rd;
        logic [31:0] w_res;
        logic [4:0]  n_rs, n_rt;
        logic        e_v;
        logic [31:0] e_a, e_b, e_st;
        logic [1:0]  e_fa, e_fb;
        logic [4:0]  e_rd;
        logic [5:0]  e_fun;
        logic        e_lu;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_id(input vec_t t);
        bus.id_valid    = t.v;
        bus.id_rs_data  = t.rs_d;
        bus.id_rt_data  = t.rt_d;
        bus.id_rs_addr  = t.rs;
        bus.id_rt_addr  = t.rt;
        bus.id_rd_addr  = t.rd;
        bus.id_shamt    = t.sh;
        bus.id_imm32    = t.imm;
        bus.id_alusrc_a = t.asa;
        bus.id_alusrc_b = t.asb;
        bus.id_alufun   = t.fun;
        bus.id_regwrite = t.rw;
        bus.id_memread  = t.mr;
        bus.id_memwrite = t.mw;
    endtask

    task automatic fwd_off();
        bus.mem_regwrite = 1'b0;
        bus.mem_rd_addr  = 5'd0;
        bus.mem_result   = 32'd0;
        bus.wb_regwrite  = 1'b0;
        bus.wb_rd_addr   = 5'd0;
        bus.wb_result    = 32'd0;
    endtask

    task automatic apply(input int i, input vec_t t);
        @(negedge clk);
        drive_id(t);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        fwd_off();
        @(posedge clk);
        #1;
        bus.id_rs_addr   = t.n_rs;
        bus.id_rt_addr   = t.n_rt;
        bus.id_valid     = 1'b1;
        bus.mem_regwrite = t.m_rw;
        bus.mem_rd_addr  = t.m_rd;
        bus.mem_result   = t.m_res;
        bus.wb_regwrite  = t.w_rw;
        bus.wb_rd_addr   = t.w_rd;
        bus.wb_result    = t.w_res;
        #1;
        chk($sformatf("v%0d.valid", i), bus.ex_valid, t.e_v);
        chk($sformatf("v%0d.alu_a", i), bus.ex_alu_a, t.e_a);
        chk($sformatf("v%0d.alu_b", i), bus.ex_alu_b, t.e_b);
        chk($sformatf("v%0d.store", i), bus.ex_store_data, t.e_st);
        chk($sformatf("v%0d.fwd_a", i), bus.ex_fwd_a, t.e_fa);
        chk($sformatf("v%0d.fwd_b", i), bus.ex_fwd_b, t.e_fb);
        chk($sformatf("v%0d.rd", i), bus.ex_rd_addr, t.e_rd);
        chk($sformatf("v%0d.alufun", i), bus.ex_alufun, t.e_fun);
        chk($sformatf("v%0d.lu", i), bus.load_use_hazard, t.e_lu);
        chk($sformatf("v%0d.regwrite", i), bus.ex_regwrite, t.v & t.rw);
        chk($sformatf("v%0d.memread", i), bus.ex_memread, t.v & t.mr);
        chk($sformatf("v%0d.memwrite", i), bus.ex_memwrite, t.v & t.mw);
    endtask

    initial begin
        //            v rs_d        rt_d          rs rt rd sh imm     asa asb fun    rw mr mw | m_rw m_rd m_res        w_rw w_rd w_res   | n_rs n_rt | e_v e_a          e_b          e_st         fa fb rd fun    lu
        vecs[0]  = '{1, 0,          3,            0, 2, 3, 5, 0,      1,  0,  6'h00, 1, 0, 0,   0,   0,   0,           0,   0,   0,       0,   0,     1,  5,           3,           3,           0, 0, 3, 6'h00, 0};
        vecs[1]  = '{1, 'hAA,       'h55,         4, 5, 6, 0, 0,      0,  0,  6'h20, 1, 0, 0,   1,   4,   'h11,        1,   4,   'h22,    0,   0,     1,  'h11,        'h55,        'h55,        2, 0, 6, 6'h20, 0};
        vecs[2]  = '{1, 'hAA,       'h55,         4, 5, 6, 0, 0,      0,  0,  6'h20, 1, 0, 0,   0,   4,   'h11,        1,   4,   'h22,    0,   0,     1,  'h22,        'h55,        'h55,        1, 0, 6, 6'h20, 0};
        vecs[3]  = '{1, 'hAA,       'h55,         4, 5, 6, 0, 0,      0,  0,  6'h20, 1, 0, 0,   1,   0,   'h11,        1,   4,   'h22,    0,   0,     1,  'h22,        'h55,        'h55,        1, 0, 6, 6'h20, 0};
        vecs[4]  = '{1, 'hAA,       'h55,         4, 5, 6, 0, 0,      0,  0,  6'h20, 1, 0, 0,   1,   0,   'h11,        1,   0,   'h22,    0,   0,     1,  'hAA,        'h55,        'h55,        0, 0, 6, 6'h20, 0};
        vecs[5]  = '{1, 1,          'h55,         3, 5, 7, 0, 'h1234, 0,  1,  6'h21, 1, 0, 0,   0,   0,   0,           1,   5,   'h77,    0,   0,     1,  1,           'h1234,      'h77,        0, 1, 7, 6'h21, 0};
        vecs[6]  = '{1, 'h100,      0,            1, 0, 8, 0, 4,      0,  1,  6'h20, 1, 1, 0,   0,   0,   0,           0,   0,   0,       0,   8,     1,  'h100,       4,           0,           0, 0, 8, 6'h20, 1};
        vecs[7]  = '{1, 'h100,      0,            1, 0, 8, 0, 4,      0,  1,  6'h20, 1, 1, 0,   0,   0,   0,           0,   0,   0,       8,   0,     1,  'h100,       4,           0,           0, 0, 8, 6'h20, 1};
        vecs[8]  = '{1, 'h100,      0,            1, 0, 0, 0, 4,      0,  1,  6'h20, 1, 1, 0,   0,   0,   0,           0,   0,   0,       0,   0,     1,  'h100,       4,           0,           0, 0, 0, 6'h20, 0};
        vecs[9]  = '{1, 'h100,      0,            1, 0, 8, 0, 4,      0,  1,  6'h20, 1, 1, 0,   0,   0,   0,           0,   0,   0,       9,   10,    1,  'h100,       4,           0,           0, 0, 8, 6'h20, 0};
        vecs[10] = '{0, 0,          0,            4, 4, 8, 0, 0,      0,  0,  6'h2A, 1, 1, 1,   1,   4,   0,           0,   0,   0,       0,   0,     0,  0,           0,           0,           0, 0, 0, 6'h00, 0};
        vecs[11] = '{1, 0,          'h80000000,   9, 10,11,0, 0,      0,  0,  6'h07, 1, 0, 0,   1,   9,   'hFFFFFFE3,  0,   0,   0,       0,   0,     1,  'hFFFFFFE3,  'h80000000,  'h80000000,  2, 0, 11,6'h07, 0};
        vecs[12] = '{1, 'h40,       0,            2, 12,0, 0, 8,      0,  1,  6'h28, 0, 0, 1,   1,   12,  'hDEAD,      1,   12,  'hBEEF,  0,   0,     1,  'h40,        8,           'hDEAD,      0, 2, 0, 6'h28, 0};

        bus.stall = 1'b0;
        bus.flush = 1'b0;
        fwd_off();
        drive_id(vecs[0]);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.id_valid    = 1'b1;
            bus.id_rs_data  = $urandom;
            bus.id_rt_data  = $urandom;
            bus.id_rs_addr  = 5'($urandom);
            bus.id_rt_addr  = 5'($urandom);
            bus.id_rd_addr  = 5'($urandom);
            bus.id_shamt    = 5'($urandom);
            bus.id_imm32    = $urandom;
            bus.id_alusrc_a = 1'($urandom);
            bus.id_alusrc_b = 1'($urandom);
            bus.id_alufun   = 6'($urandom);
            bus.id_regwrite = 1'b1;
            bus.id_memread  = 1'b1;
            bus.id_memwrite = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rst.valid", bus.ex_valid, 0);
        chk("rst.regwrite", bus.ex_regwrite, 0);
        chk("rst.memread", bus.ex_memread, 0);
        chk("rst.memwrite", bus.ex_memwrite, 0);
        chk("rst.alufun", bus.ex_alufun, 0);
        chk("rst.alu_a", bus.ex_alu_a, 0);
        chk("rst.alu_b", bus.ex_alu_b, 0);
        chk("rst.store", bus.ex_store_data, 0);
        chk("rst.fwd_a", bus.ex_fwd_a, 0);
        chk("rst.fwd_b", bus.ex_fwd_b, 0);
        chk("rst.lu", bus.load_use_hazard, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) apply(i, vecs[i]);

        // Load-use detected, then the flush turns the next capture into a bubble.
        apply(20, vecs[6]);
        @(negedge clk);
        drive_id(vecs[0]);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        chk("lu_flush.valid", bus.ex_valid, 0);
        chk("lu_flush.regwrite", bus.ex_regwrite, 0);
        chk("lu_flush.memread", bus.ex_memread, 0);
        chk("lu_flush.alufun", bus.ex_alufun, 0);
        @(negedge clk);
        bus.flush = 1'b0;

        // X captured, held through a 3-cycle stall with a flush in the middle.
        drive_id(vecs[1]);
        fwd_off();
        @(posedge clk);
        #1;
        chk("stall.x_valid", bus.ex_valid, 1);
        chk("stall.x_rd", bus.ex_rd_addr, 6);
        drive_id(vecs[5]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.stall = 1'b1;
            bus.flush = (c == 1);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d.valid", c), bus.ex_valid, 1);
            chk($sformatf("stall%0d.rd", c), bus.ex_rd_addr, 6);
            chk($sformatf("stall%0d.alufun", c), bus.ex_alufun, 6'h20);
            chk($sformatf("stall%0d.alu_a", c), bus.ex_alu_a, 'hAA);
        end
        bus.mem_regwrite = 1'b1;
        bus.mem_rd_addr  = 5'd4;
        bus.mem_result   = 32'h999;
        #1;
        chk("stall.track_a", bus.ex_alu_a, 'h999);
        chk("stall.track_fwd_a", bus.ex_fwd_a, 2);
        @(negedge clk);
        fwd_off();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        @(posedge clk);
        #1;
        chk("stall.bubble_valid", bus.ex_valid, 0);
        chk("stall.bubble_regwrite", bus.ex_regwrite, 0);
        @(posedge clk);
        #1;
        chk("stall.resume_valid", bus.ex_valid, 1);
        chk("stall.resume_rd", bus.ex_rd_addr, 7);
        chk("stall.resume_alufun", bus.ex_alufun, 6'h21);

        // Reset during a stall also drops the pending flush.
        @(negedge clk);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_stall.valid", bus.ex_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.stall = 1'b0;
        drive_id(vecs[1]);
        @(posedge clk);
        #1;
        chk("rst_stall.capture_valid", bus.ex_valid, 1);
        chk("rst_stall.capture_rd", bus.ex_rd_addr, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
